mini_mips_multicycle: RTL and testbench
=======================================

Name: mini_mips_multicycle

Overview:
Clocked, parametrised successor to the single-cycle 16-bit-instruction mini MIPS datapath. It accepts one instruction at a time over a valid/ready handshake and executes it through a DECODE/EXEC/MEM/WB state machine. It holds an 8-entry register file and a word-addressed data memory, and reports each retired instruction's write-back value with a one-cycle result_valid pulse. It sits between an external instruction sequencer (testbench or fetch unit) and the debug/observation logic.

Parameters:
DATA_W, 32, register, ALU and memory word width (>= 8)
DMEM_DEPTH, 64, data memory words (power of two)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
instr_valid  input  1  instruction offered
instr_ready  output  1  block in IDLE and able to accept
instruction  input  16  [15:12] opcode, [11:9] rs, [8:6] rt, [5:3] rd, [2:0] funct, [5:0] imm
result  output  DATA_W  write-back value of the retiring instruction
result_valid  output  1  one-cycle pulse at retirement
illegal  output  1  one-cycle pulse, with result_valid, for an undefined opcode or funct
busy  output  1  high in any state other than IDLE
retired_count  output  CNT_W  count of retired instructions, including illegal ones

Behaviour:
- Reset (synchronous):
  - State goes to IDLE.
  - All 8 registers cleared to 0; result = 0; result_valid = illegal = 0; retired_count = 0.
  - Data memory contents are not reset.
- Reset asserted mid-instruction: the instruction is aborted. No register or memory write occurs, and no result_valid pulse is issued.
- Register 0 always reads 0. Writes to register 0 are discarded, but result still shows the computed value.
- Handshake:
  - instr_ready = 1 only in IDLE.
  - The instruction is latched on the edge where instr_valid && instr_ready.
  - instruction is ignored in every other cycle.
- State machine:
  - IDLE -> DECODE on accept.
  - DECODE: read rs/rt, sign-extend imm[5:0] to DATA_W, decode.
  - DECODE -> EXEC.
  - EXEC: compute the ALU result and register it.
  - EXEC -> MEM for lw/sw; EXEC -> WB for all other instructions.
  - MEM: lw reads memory; sw writes memory at the end of the cycle.
  - MEM -> WB.
  - WB: result_valid = 1; register write (if any) at the end of the cycle; retired_count increments.
  - WB -> IDLE.
- Latency, counted from the accept edge:
  - ALU instructions: result_valid in the 3rd cycle after accept.
  - lw/sw: result_valid in the 4th cycle after accept.
  - Next accept is possible in the cycle after WB.
- Opcodes:
  - 0000 R-type, writes rd. funct: 000 add, 001 sub, 010 and, 011 or, 100 slt (signed, result 1 or 0), 101 nor. funct 110/111 are illegal.
  - 0001 addi, 0010 andi, 0011 ori, 0100 slti: write rt; operand B is the sign-extended imm.
  - 0101 lw: rt <= mem[addr], addr = rs + sext(imm).
  - 0110 sw: mem[addr] <= rt; result = addr (full ALU value); no register write.
  - 0111-1111: illegal.
- Illegal instruction: EXEC -> WB with no register or memory write; result = 0; illegal pulses together with result_valid.
- Arithmetic: two's complement modulo 2^DATA_W; overflow is ignored.
- Address: word index = ALU result [log2(DMEM_DEPTH)-1:0]. Upper bits are ignored, so addresses wrap.
- result holds its last value outside WB. retired_count wraps at 2^CNT_W.
- Read-after-write: the WB register write is visible to the next instruction's DECODE.

Test Plan:
- Reset, then offer addi r1,r0,5 (0x1045) -> accepted; result_valid in the 3rd cycle with result = 5; retired_count = 1; instr_ready high the following cycle.
- addi r2,r0,-3 (imm 0x3D), then add r3,r1,r2 (0x0298) -> second result = 2. slt r4,r2,r1 -> 1. sub r5,r2,r1 -> 0xFFFFFFF8.
- sw r1,4(r0) (0x6044), then lw r6,4(r0) (0x5184) -> sw result = 4 in the 4th cycle; lw result = 5; r6 = 5. With DMEM_DEPTH = 64, lw from address 68 returns the same word (wrap).
- Opcode 0xF, and R-type funct 111 -> result_valid and illegal both pulse, result = 0; a register dump shows no changes; retired_count increments.
- Hold instr_valid high continuously -> exactly one accept per IDLE visit; a new instruction presented during busy is not latched until IDLE.
- Assert reset during the MEM state of a sw -> memory word is unchanged; no result_valid; state IDLE and registers 0 in the next cycle.

Source files
------------

// File: rtl/mini_mips_multicycle.sv
// Multicycle mini MIPS core: one 16-bit instruction at a time through DECODE/EXEC/MEM/WB,
// with an 8-entry register file, word-addressed data memory and a retired-instruction counter.
module mini_mips_multicycle #(
    parameter int DATA_W     = 32,
    parameter int DMEM_DEPTH = 64,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instruction,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              illegal,
    output logic              busy,
    output logic [CNT_W-1:0]  retired_count
);
    localparam int AW = $clog2(DMEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t state_q, state_d;

    logic        [15:0]       instr_q, instr_d;
    logic signed [DATA_W-1:0] a_q, a_d;
    logic signed [DATA_W-1:0] b_q, b_d;
    logic signed [DATA_W-1:0] rtv_q, rtv_d;
    logic signed [DATA_W-1:0] alu_q, alu_d;
    logic        [DATA_W-1:0] result_q, result_d;
    logic        [CNT_W-1:0]  cnt_q, cnt_d;
    logic        [DATA_W-1:0] rf_q [8];
    logic        [DATA_W-1:0] rf_d [8];
    logic        [DATA_W-1:0] dmem_q [DMEM_DEPTH];

    logic [3:0]               opcode;
    logic [2:0]               rs, rt, rd, funct, dest, alu_sel;
    logic signed [DATA_W-1:0] imm_sext, alu_res;
    logic                     is_rtype, is_lw, is_sw, is_ill, wr_en, mem_we;
    logic [AW-1:0]            mem_addr;

    // sel: 0 add, 1 sub, 2 and, 3 or, 4 signed set-less-than, 5 nor
    function automatic logic signed [DATA_W-1:0] alu_fn(
        input logic [2:0]               sel,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] r;
        case (sel)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = (a < b) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
            3'd5:    r = ~(a | b);
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        opcode   = instr_q[15:12];
        rs       = instr_q[11:9];
        rt       = instr_q[8:6];
        rd       = instr_q[5:3];
        funct    = instr_q[2:0];
        imm_sext = {{(DATA_W-6){instr_q[5]}}, instr_q[5:0]};
        is_rtype = (opcode == 4'd0);
        is_lw    = (opcode == 4'd5);
        is_sw    = (opcode == 4'd6);
        is_ill   = (opcode >= 4'd7) || (is_rtype && funct[2:1] == 2'b11);
        dest     = is_rtype ? rd : rt;
        wr_en    = !is_ill && !is_sw;
        case (opcode)
            4'd0:    alu_sel = funct;
            4'd2:    alu_sel = 3'd2;
            4'd3:    alu_sel = 3'd3;
            4'd4:    alu_sel = 3'd4;
            default: alu_sel = 3'd0;
        endcase
        alu_res  = alu_fn(alu_sel, a_q, b_q);
        mem_addr = alu_q[AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (instr_valid) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = (is_lw || is_sw) ? S_MEM : S_WB;
            S_MEM:    state_d = S_WB;
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready  = (state_q == S_IDLE) && !reset;
        busy         = (state_q != S_IDLE);
        result_valid = (state_q == S_WB) && !reset;
        illegal      = (state_q == S_WB) && !reset && is_ill;
    end

    // Datapath: each state advances exactly one piece of the instruction's work.
    always_comb begin
        instr_d  = instr_q;
        a_d      = a_q;
        b_d      = b_q;
        rtv_d    = rtv_q;
        alu_d    = alu_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        rf_d     = rf_q;
        mem_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) instr_d = instruction;
            end
            S_DECODE: begin
                a_d   = rf_q[rs];
                rtv_d = rf_q[rt];
                b_d   = is_rtype ? rf_q[rt] : imm_sext;
            end
            S_EXEC: begin
                alu_d = alu_res;
                if (!is_lw && !is_sw) result_d = is_ill ? '0 : alu_res;
            end
            S_MEM: begin
                result_d = is_lw ? dmem_q[mem_addr] : alu_q;
                mem_we   = is_sw && !reset;
            end
            S_WB: begin
                if (wr_en && dest != 3'd0) rf_d[dest] = result_q;
                cnt_d = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            result_q <= result_d;
            cnt_q    <= cnt_d;
            rf_q     <= rf_d;
        end
    end

    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        a_q     <= a_d;
        b_q     <= b_d;
        rtv_q   <= rtv_d;
        alu_q   <= alu_d;
    end

    // Memory is deliberately left out of reset; an aborted sw never raises mem_we.
    always_ff @(posedge clk) begin
        if (mem_we) dmem_q[mem_addr] <= rtv_q;
    end

    assign result        = result_q;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_mini_mips_multicycle.sv
// Bench for mini_mips_multicycle: directed and random instruction streams checked every cycle
// against an instruction-level model of registers, memory and retirement timing.
module tb_mini_mips_multicycle;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instruction = 16'h0;
    logic        instr_ready, result_valid, illegal, busy;
    logic [31:0] result;
    logic [15:0] retired_count;

    mini_mips_multicycle #(.DATA_W(32), .DMEM_DEPTH(64), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .result(result), .result_valid(result_valid),
        .illegal(illegal), .busy(busy), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_reg [8];
    logic [31:0] m_mem [64];
    bit          pend = 0;
    int          exp_cyc = 0;
    logic [31:0] exp_res = 0;
    bit          exp_ill = 0;
    bit          lit_en = 0;
    logic [31:0] lit_val = 0;
    int          exp_cnt = 0;
    logic [31:0] last_res = 0;
    bit          chk_on = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", nm, cyc, act, req);
        end
    endtask

    // Instruction-level reference: applies one instruction to the model state.
    function automatic void model_step(input logic [15:0] ins, output logic [31:0] res,
                                       output bit ill, output int lat);
        logic [3:0]  op   = ins[15:12];
        logic [31:0] a    = m_reg[ins[11:9]];
        logic [31:0] b    = m_reg[ins[8:6]];
        logic [31:0] imm  = {{26{ins[5]}}, ins[5:0]};
        logic [31:0] addr = a + imm;
        int          dest = int'(ins[8:6]);
        ill = 0;
        lat = 2;
        res = 0;
        case (op)
            4'd0: begin
                dest = int'(ins[5:3]);
                case (ins[2:0])
                    3'd0: res = a + b;
                    3'd1: res = a - b;
                    3'd2: res = a & b;
                    3'd3: res = a | b;
                    3'd4: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd5: res = ~(a | b);
                    default: ill = 1;
                endcase
            end
            4'd1: res = a + imm;
            4'd2: res = a & imm;
            4'd3: res = a | imm;
            4'd4: res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            4'd5: begin res = m_mem[addr[5:0]]; lat = 3; end
            4'd6: begin m_mem[addr[5:0]] = b; res = addr; lat = 3; dest = 0; end
            default: ill = 1;
        endcase
        if (ill) begin res = 0; dest = 0; end
        if (dest != 0) m_reg[dest] = res;
    endfunction

    // Single compare process: every cycle outside reset.
    always @(negedge clk) begin
        if (chk_on && !reset) begin
            if (pend && cyc == exp_cyc) begin
                chk("result_valid", {31'd0, result_valid}, 32'd1);
                chk("result", result, exp_res);
                chk("illegal", {31'd0, illegal}, {31'd0, exp_ill});
                if (lit_en) chk("literal", result, lit_val);
                chk("count_in_wb", {16'd0, retired_count}, {16'd0, 16'(exp_cnt)});
                pend = 0;
                exp_cnt++;
                last_res = exp_res;
            end else begin
                chk("no_valid", {31'd0, result_valid}, 32'd0);
                chk("no_illegal", {31'd0, illegal}, 32'd0);
                chk("result_hold", result, last_res);
                chk("count", {16'd0, retired_count}, {16'd0, 16'(exp_cnt)});
            end
            chk("ready_vs_busy", {31'd0, instr_ready}, {31'd0, !busy});
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // Keeps instr_valid high and puts junk on the bus while busy.
    task automatic issue(input logic [15:0] ins, input bit use_lit, input logic [31:0] lit);
        logic [31:0] r;
        bit          il;
        int          lat;
        wait_ready();
        instr_valid = 1'b1;
        instruction = ins;
        @(posedge clk);
        #1;
        model_step(ins, r, il, lat);
        exp_res = r;
        exp_ill = il;
        lit_en  = use_lit;
        lit_val = lit;
        exp_cyc = cyc + lat;
        pend    = 1;
        instruction = 16'($urandom);
    endtask

    task automatic drain();
        wait_ready();
        instr_valid = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 0;
        exp_cnt  = 0;
        last_res = 0;
        pend     = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [5:0]  v6;
        logic [3:0]  op;
        int          k;
        model_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_on = 1;

        issue(16'h1045, 1, 32'd5);
        issue(16'h10BD, 1, 32'hFFFF_FFFD);
        issue(16'h0298, 1, 32'd2);
        issue(16'h0464, 1, 32'd1);
        issue(16'h0469, 1, 32'hFFFF_FFF8);
        issue(16'h6044, 1, 32'd4);
        issue(16'h5184, 1, 32'd5);
        issue(16'h11DF, 1, 32'd31);
        issue(16'h0FF8, 1, 32'd62);
        issue(16'h1FC6, 1, 32'd68);
        issue(16'h5F80, 1, 32'd5);
        issue(16'hF000, 1, 32'd0);
        issue(16'h029F, 1, 32'd0);
        issue(16'h0623, 1, 32'd2);
        issue(16'h1201, 1, 32'd6);
        issue(16'h0028, 1, 32'd0);

        for (int i = 0; i < 64; i++) begin
            v6 = 6'($urandom);
            issue({4'h1, 3'd0, 3'd7, v6}, 0, 0);
            issue({4'h6, 3'd0, 3'd7, 6'(i)}, 0, 0);
        end

        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 8));
            if (op > 4'd6) op = 4'($urandom_range(7, 15));
            issue({op, 12'($urandom)}, 0, 0);
        end
        drain();

        w  = m_mem[10];
        v6 = {2'b01, w[3:0] ^ 4'h1};
        issue({4'h1, 3'd0, 3'd1, v6}, 0, 0);
        drain();
        @(negedge clk);
        instr_valid = 1'b1;
        instruction = 16'h604A;
        @(posedge clk);
        #1;
        k = cyc;
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_in_mem", {31'd0, busy}, 32'd1);
        chk("abort_cycle", cyc, k + 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_count", {16'd0, retired_count}, 32'd0);
        chk("abort_result", result, 32'd0);
        issue(16'h508A, 1, w);
        issue(16'h0218, 1, 32'd0);
        drain();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
